// File: rtl/scan_sample_pkg.sv
// Shared types and sizing helpers for the scan sample history block.
// Optional feature macro used by the design: SCAN_SAMPLE_UPDATE_EN
package scan_sample_pkg;

  // Controller states, 2-bit encoding
  typedef enum logic [1:0] {
    ST_IDLE    = 2'd0,
    ST_CAPTURE = 2'd1,
    ST_SHIFT   = 2'd2,
    ST_DONE    = 2'd3
  } state_e;

  // Default geometry of the history block
  localparam int DEF_WIDTH      = 8;
  localparam int DEF_DEPTH      = 4;
  localparam int DEF_SCAN_WIDTH = 1;

  // Integer ceiling division
  function automatic int ceil_div(input int a, input int b);
    return (a + b - 1) / b;
  endfunction

  // L: total history bits
  function automatic int hist_bits(input int width, input int depth);
    return width * depth;
  endfunction

  // N: beats needed to move the whole history out
  function automatic int num_beats(input int width, input int depth, input int scanWidth);
    return ceil_div(hist_bits(width, depth), scanWidth);
  endfunction

  // P: shadow length, history rounded up to a whole number of beats
  function automatic int shadow_bits(input int width, input int depth, input int scanWidth);
    return num_beats(width, depth, scanWidth) * scanWidth;
  endfunction

  // CNT_W: counter width able to hold the value N itself
  function automatic int cnt_bits(input int width, input int depth, input int scanWidth);
    return $clog2(num_beats(width, depth, scanWidth)) + 1;
  endfunction

endpackage

// File: rtl/scan_shadow_shifter.sv
// Shadow snapshot register with parallel load, LSB-first shift and beat counter.
// With SCAN_SAMPLE_UPDATE_EN defined the full shadow word is exported so the
// top level can write scanned-in data back into the history.
module scan_shadow_shifter
  import scan_sample_pkg::*;
#(
  parameter int P          = 32,
  parameter int SCAN_WIDTH = 1,
  parameter int N          = 32,
  parameter int CNT_W      = 6
) (
  input  logic                  clk_i,
  input  logic                  rst_i,
`ifdef SCAN_SAMPLE_UPDATE_EN
  output logic [P-1:0]          shadow_o,
`endif
  input  logic                  load_i,
  input  logic                  shift_i,
  input  logic [P-1:0]          load_data_i,
  input  logic [SCAN_WIDTH-1:0] scan_in_i,
  output logic [SCAN_WIDTH-1:0] scan_out_o,
  output logic [CNT_W-1:0]      cnt_o,
  output logic                  last_o
);

  logic [P-1:0]     shadowWord_q;
  logic [P-1:0]     shadowWord_d;
  logic [P-1:0]     shiftedWord;
  logic [CNT_W-1:0] beatCnt_q;
  logic [CNT_W-1:0] beatCnt_d;

  // New serial data enters at the top while the bottom beat leaves
  if (P > SCAN_WIDTH) begin : g_wide
    assign shiftedWord = {scan_in_i, shadowWord_q[P-1:SCAN_WIDTH]};
  end else begin : g_single
    assign shiftedWord = scan_in_i;
  end

  // Next shadow and counter: load restarts the count, each shift adds one beat
  always_comb begin
    shadowWord_d = shadowWord_q;
    beatCnt_d    = beatCnt_q;
    if (load_i) begin
      shadowWord_d = load_data_i;
      beatCnt_d    = '0;
    end else if (shift_i) begin
      shadowWord_d = shiftedWord;
      beatCnt_d    = beatCnt_q + CNT_W'(1);
    end
  end

  // Shadow and counter registers, cleared by asynchronous reset
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      shadowWord_q <= '0;
      beatCnt_q    <= '0;
    end else begin
      shadowWord_q <= shadowWord_d;
      beatCnt_q    <= beatCnt_d;
    end
  end

  assign scan_out_o = shadowWord_q[SCAN_WIDTH-1:0];
  assign cnt_o      = beatCnt_q;
  assign last_o     = (beatCnt_q == CNT_W'(N - 1));

`ifdef SCAN_SAMPLE_UPDATE_EN
  assign shadow_o = shadowWord_q;
`endif

endmodule

// File: rtl/scan_sample_history.sv
// DEPTH-deep sample history with a scan capture/shift controller.
// Define SCAN_SAMPLE_UPDATE_EN to write the scanned-in shadow contents back
// into the history when a scan completes; otherwise the history is untouched
// by scanning and the shifted-in data is simply discarded.
module scan_sample_history
  import scan_sample_pkg::*;
#(
  parameter  int WIDTH      = DEF_WIDTH,
  parameter  int DEPTH      = DEF_DEPTH,
  parameter  int SCAN_WIDTH = DEF_SCAN_WIDTH,
  localparam int CNT_W      = cnt_bits(WIDTH, DEPTH, SCAN_WIDTH)
) (
  input  logic                  clk_i,
  input  logic                  rst_i,
  input  logic [WIDTH-1:0]      d_in_i,
  input  logic                  d_en_i,
  output logic [WIDTH-1:0]      q_out_o,
  input  logic                  start_i,
  input  logic                  scan_en_i,
  input  logic [SCAN_WIDTH-1:0] scan_in_i,
  output logic [SCAN_WIDTH-1:0] scan_out_o,
  output logic                  busy_o,
  output logic                  done_o,
  output logic [CNT_W-1:0]      beat_cnt_o
);

  localparam int N = num_beats(WIDTH, DEPTH, SCAN_WIDTH);
  localparam int P = shadow_bits(WIDTH, DEPTH, SCAN_WIDTH);

  state_e           state_q;
  state_e           state_d;
  logic [WIDTH-1:0] hist_q [DEPTH];
  logic [WIDTH-1:0] hist_d [DEPTH];
  logic [P-1:0]     packedHist;
  logic             loadShadow;
  logic             shiftBeat;
  logic             lastBeat;

`ifdef SCAN_SAMPLE_UPDATE_EN
  logic [P-1:0]     shadowWord;
`endif

  // Pack the history into the shadow layout: hist[0] in the low bits, pad bits zero
  always_comb begin
    packedHist = '0;
    for (int i = 0; i < DEPTH; i++) begin
      packedHist[i*WIDTH +: WIDTH] = hist_q[i];
    end
  end

  // Controller: capture one cycle, shift N enabled beats, flag done for one cycle
  always_comb begin
    state_d    = state_q;
    loadShadow = 1'b0;
    shiftBeat  = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (start_i) begin
          state_d = ST_CAPTURE;
        end
      end
      ST_CAPTURE: begin
        loadShadow = 1'b1;
        state_d    = ST_SHIFT;
      end
      ST_SHIFT: begin
        if (scan_en_i) begin
          shiftBeat = 1'b1;
          if (lastBeat) begin
            state_d = ST_DONE;
          end
        end
      end
      ST_DONE: begin
        state_d = ST_IDLE;
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

  // Controller state register
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state_q <= ST_IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // History next state: sampling only while idle, optional write-back when a scan completes
  always_comb begin
    hist_d = hist_q;
    if ((state_q == ST_IDLE) && d_en_i) begin
      hist_d[0] = d_in_i;
      for (int i = 1; i < DEPTH; i++) begin
        hist_d[i] = hist_q[i-1];
      end
    end
`ifdef SCAN_SAMPLE_UPDATE_EN
    if (state_q == ST_DONE) begin
      for (int i = 0; i < DEPTH; i++) begin
        hist_d[i] = shadowWord[i*WIDTH +: WIDTH];
      end
    end
`endif
  end

  // History registers, cleared by asynchronous reset
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      for (int i = 0; i < DEPTH; i++) begin
        hist_q[i] <= '0;
      end
    end else begin
      hist_q <= hist_d;
    end
  end

  scan_shadow_shifter #(
    .P          (P),
    .SCAN_WIDTH (SCAN_WIDTH),
    .N          (N),
    .CNT_W      (CNT_W)
  ) u_shifter (
    .clk_i       (clk_i),
    .rst_i       (rst_i),
`ifdef SCAN_SAMPLE_UPDATE_EN
    .shadow_o    (shadowWord),
`endif
    .load_i      (loadShadow),
    .shift_i     (shiftBeat),
    .load_data_i (packedHist),
    .scan_in_i   (scan_in_i),
    .scan_out_o  (scan_out_o),
    .cnt_o       (beat_cnt_o),
    .last_o      (lastBeat)
  );

  assign q_out_o = hist_q[0];
  assign busy_o  = (state_q != ST_IDLE);
  assign done_o  = (state_q == ST_DONE);

endmodule

// File: tb/tb_scan_sample_history.sv
// Self-checking bench for scan_sample_history.
// Instance A (WIDTH=8, DEPTH=4, SCAN_WIDTH=4) is checked every cycle against a
// queue-based behavioural model; instance B (SCAN_WIDTH=3) gets directed checks.
// Expectations follow SCAN_SAMPLE_UPDATE_EN when it is defined.
module tb_scan_sample_history;

  localparam int PH_IDLE    = 0;
  localparam int PH_CAPTURE = 1;
  localparam int PH_SHIFT   = 2;
  localparam int PH_DONE    = 3;

  logic       clk;
  logic       rst;
  logic       rstB;

  logic [7:0] aDIn;
  logic       aDEn;
  logic       aStart;
  logic       aScanEn;
  logic [3:0] aScanIn;
  logic [7:0] aQOut;
  logic [3:0] aScanOut;
  logic       aBusy;
  logic       aDone;
  logic [3:0] aBeatCnt;

  logic [7:0] bDIn;
  logic       bDEn;
  logic       bStart;
  logic       bScanEn;
  logic [2:0] bScanIn;
  logic [7:0] bQOut;
  logic [2:0] bScanOut;
  logic       bBusy;
  logic       bDone;
  logic [4:0] bBeatCnt;

  int checkCount = 0;
  int errorCount = 0;
  bit cmpOn = 0;

  logic [3:0] beatLog [16];
  int         beatsSeen;
  int         doneCycle;

  // Behavioural model state for instance A
  logic [7:0] mHist [4];
  logic [3:0] mQ [$];
  int         mPhase;
  int         mCnt;

  scan_sample_history #(.WIDTH(8), .DEPTH(4), .SCAN_WIDTH(4)) dutA (
    .clk_i(clk), .rst_i(rst), .d_in_i(aDIn), .d_en_i(aDEn), .q_out_o(aQOut),
    .start_i(aStart), .scan_en_i(aScanEn), .scan_in_i(aScanIn), .scan_out_o(aScanOut),
    .busy_o(aBusy), .done_o(aDone), .beat_cnt_o(aBeatCnt)
  );

  scan_sample_history #(.WIDTH(8), .DEPTH(4), .SCAN_WIDTH(3)) dutB (
    .clk_i(clk), .rst_i(rstB), .d_in_i(bDIn), .d_en_i(bDEn), .q_out_o(bQOut),
    .start_i(bStart), .scan_en_i(bScanEn), .scan_in_i(bScanIn), .scan_out_o(bScanOut),
    .busy_o(bBusy), .done_o(bDone), .beat_cnt_o(bBeatCnt)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Compare one value and log a failure line on mismatch
  task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
    checkCount++;
    if (actual !== expected) begin
      errorCount++;
      $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, actual, expected, $time);
    end
  endtask

  // Drive instance A inputs for one clock, returning just after the sampling edge
  task automatic applyStimulus(input logic dEn, input logic [7:0] dIn, input logic start,
                               input logic scanEn, input logic [3:0] scanIn);
    aDEn = dEn; aDIn = dIn; aStart = start; aScanEn = scanEn; aScanIn = scanIn;
    @(posedge clk);
    #1;
  endtask

  // Drive instance B inputs for one clock
  task automatic applyB(input logic dEn, input logic [7:0] dIn, input logic start,
                        input logic scanEn, input logic [2:0] scanIn);
    bDEn = dEn; bDIn = dIn; bStart = start; bScanEn = scanEn; bScanIn = scanIn;
    @(posedge clk);
    #1;
  endtask

  // Behavioural model: history as an array, shadow as a queue of beats
  always @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < 4; i++) mHist[i] = 8'h00;
      mQ.delete();
      mPhase = PH_IDLE;
      mCnt   = 0;
    end else begin
      case (mPhase)
        PH_IDLE: begin
          if (aDEn) begin
            for (int i = 3; i > 0; i--) mHist[i] = mHist[i-1];
            mHist[0] = aDIn;
          end
          if (aStart) mPhase = PH_CAPTURE;
        end
        PH_CAPTURE: begin
          mQ.delete();
          for (int i = 0; i < 4; i++) begin
            mQ.push_back(mHist[i][3:0]);
            mQ.push_back(mHist[i][7:4]);
          end
          mCnt   = 0;
          mPhase = PH_SHIFT;
        end
        PH_SHIFT: begin
          if (aScanEn) begin
            void'(mQ.pop_front());
            mQ.push_back(aScanIn);
            mCnt++;
            if (mCnt == 8) mPhase = PH_DONE;
          end
        end
        default: begin
`ifdef SCAN_SAMPLE_UPDATE_EN
          for (int i = 0; i < 4; i++) mHist[i] = {mQ[2*i+1], mQ[2*i]};
`endif
          mPhase = PH_IDLE;
        end
      endcase
    end
  end

  // Every-cycle comparison of instance A against the model
  always @(negedge clk) begin
    if (cmpOn) begin
      checkOutput("model_q_out",    32'(aQOut),    32'(mHist[0]));
      checkOutput("model_scan_out", 32'(aScanOut), (mQ.size() > 0) ? 32'(mQ[0]) : 32'h0);
      checkOutput("model_busy",     32'(aBusy),    32'(mPhase != PH_IDLE));
      checkOutput("model_done",     32'(aDone),    32'(mPhase == PH_DONE));
      checkOutput("model_beat_cnt", 32'(aBeatCnt), 32'(mCnt));
    end
  end

  // Load 0x11, 0x22, 0x33, 0x44 so that hist[0] = 0x44
  task automatic loadHistoryA();
    applyStimulus(1'b1, 8'h11, 1'b0, 1'b0, 4'h0);
    applyStimulus(1'b1, 8'h22, 1'b0, 1'b0, 4'h0);
    applyStimulus(1'b1, 8'h33, 1'b0, 1'b0, 4'h0);
    applyStimulus(1'b1, 8'h44, 1'b0, 1'b0, 4'h0);
  endtask

  // One complete scan on instance A, logging beats and the cycle DONE appears
  task automatic runScan(input bit alternate, input bit loopback, input logic [3:0] scanInVal,
                         input int injectAt);
    logic       en;
    logic [3:0] sin;
    bit         inj;
    beatsSeen = 0;
    doneCycle = -1;
    applyStimulus(1'b0, 8'h00, 1'b1, 1'b0, 4'h0);
    for (int cyc = 1; cyc < 60; cyc++) begin
      if (aDone) begin
        doneCycle = cyc;
        break;
      end
      en  = alternate ? (cyc % 2 == 1) : 1'b1;
      sin = loopback ? aScanOut : scanInVal;
      if (cyc >= 2 && en && beatsSeen < 16) begin
        beatLog[beatsSeen] = aScanOut;
        beatsSeen++;
      end
      inj = (cyc == injectAt);
      applyStimulus(inj, inj ? 8'h55 : 8'h00, inj, en, sin);
    end
    if (doneCycle < 0) begin
      checkCount++;
      errorCount++;
      $display("[TB] FAIL done_timeout: got no DONE, expected DONE within 60 cycles");
    end
  endtask

  // Compare the logged beats with the 0x11..0x44 pattern or an all-0xA pattern
  task automatic checkBeats(input string name, input bit allA);
    logic [3:0] stdBeats [8];
    stdBeats = '{4'h4, 4'h4, 4'h3, 4'h3, 4'h2, 4'h2, 4'h1, 4'h1};
    checkOutput({name, "_count"}, 32'(beatsSeen), 32'd8);
    for (int i = 0; i < 8; i++) begin
      checkOutput($sformatf("%s_beat%0d", name, i), 32'(beatLog[i]),
                  allA ? 32'hA : 32'(stdBeats[i]));
    end
  endtask

  // Directed tests followed by a randomized run
  initial begin
    logic [2:0] bExp [11];
    int         bBeats;
    int         bDoneCycle;
    bit         sawDone;

    aDEn = 0; aDIn = 0; aStart = 0; aScanEn = 0; aScanIn = 0;
    bDEn = 0; bDIn = 0; bStart = 0; bScanEn = 0; bScanIn = 0;
    rst = 1'b1; rstB = 1'b1;
    @(posedge clk);
    #1;
    checkOutput("reset_q_out",    32'(aQOut),    32'h0);
    checkOutput("reset_scan_out", 32'(aScanOut), 32'h0);
    checkOutput("reset_busy",     32'(aBusy),    32'h0);
    checkOutput("reset_done",     32'(aDone),    32'h0);
    checkOutput("reset_beat_cnt", 32'(aBeatCnt), 32'h0);
    rst = 1'b0; rstB = 1'b0;
    cmpOn = 1'b1;

    $display("[TB] basic scan");
    loadHistoryA();
    checkOutput("load_q_out", 32'(aQOut), 32'h44);
    runScan(1'b0, 1'b1, 4'h0, 0);
    checkBeats("scan", 1'b0);
    checkOutput("scan_done_cycle", 32'(doneCycle), 32'd10);
    checkOutput("scan_done_cnt", 32'(aBeatCnt), 32'd8);
    applyStimulus(1'b0, 8'h00, 1'b0, 1'b0, 4'h0);
    checkOutput("after_done_busy", 32'(aBusy), 32'h0);
    checkOutput("after_done_cnt_hold", 32'(aBeatCnt), 32'd8);

    $display("[TB] gapped scan");
    runScan(1'b1, 1'b1, 4'h0, 0);
    checkBeats("gap", 1'b0);
    checkOutput("gap_done_cycle", 32'(doneCycle), 32'd18);
    applyStimulus(1'b0, 8'h00, 1'b0, 1'b0, 4'h0);

    $display("[TB] inputs ignored while busy");
    runScan(1'b0, 1'b1, 4'h0, 4);
    checkBeats("busy_inj", 1'b0);
    checkOutput("busy_inj_done_cycle", 32'(doneCycle), 32'd10);
    applyStimulus(1'b0, 8'h00, 1'b0, 1'b0, 4'h0);
    checkOutput("busy_inj_busy", 32'(aBusy), 32'h0);
    checkOutput("busy_inj_q_out", 32'(aQOut), 32'h44);
    runScan(1'b0, 1'b1, 4'h0, 0);
    checkBeats("rescan", 1'b0);
    applyStimulus(1'b0, 8'h00, 1'b0, 1'b0, 4'h0);

    $display("[TB] scan-in of 0xA");
    runScan(1'b0, 1'b0, 4'hA, 0);
    checkOutput("scanA_done_cycle", 32'(doneCycle), 32'd10);
    applyStimulus(1'b0, 8'h00, 1'b0, 1'b0, 4'h0);
`ifdef SCAN_SAMPLE_UPDATE_EN
    checkOutput("scanA_q_out", 32'(aQOut), 32'hAA);
    runScan(1'b0, 1'b1, 4'h0, 0);
    checkBeats("scanA_rescan", 1'b1);
`else
    checkOutput("scanA_q_out", 32'(aQOut), 32'h44);
    runScan(1'b0, 1'b1, 4'h0, 0);
    checkBeats("scanA_rescan", 1'b0);
`endif
    applyStimulus(1'b0, 8'h00, 1'b0, 1'b0, 4'h0);

    $display("[TB] async reset mid-scan");
    applyStimulus(1'b0, 8'h00, 1'b1, 1'b0, 4'h0);
    applyStimulus(1'b0, 8'h00, 1'b0, 1'b1, 4'h0);
    applyStimulus(1'b0, 8'h00, 1'b0, 1'b1, 4'h0);
    applyStimulus(1'b0, 8'h00, 1'b0, 1'b1, 4'h0);
    #2 rst = 1'b1;
    #1;
    checkOutput("async_q_out",    32'(aQOut),    32'h0);
    checkOutput("async_scan_out", 32'(aScanOut), 32'h0);
    checkOutput("async_busy",     32'(aBusy),    32'h0);
    checkOutput("async_done",     32'(aDone),    32'h0);
    checkOutput("async_beat_cnt", 32'(aBeatCnt), 32'h0);
    @(posedge clk);
    #1 rst = 1'b0;
    for (int i = 0; i < 4; i++) begin
      applyStimulus(1'b0, 8'h00, 1'b0, 1'b1, 4'hF);
      checkOutput("post_reset_busy", 32'(aBusy), 32'h0);
    end

    $display("[TB] three-bit scan width");
    applyB(1'b1, 8'h11, 1'b0, 1'b0, 3'h0);
    applyB(1'b1, 8'h22, 1'b0, 1'b0, 3'h0);
    applyB(1'b1, 8'h33, 1'b0, 1'b0, 3'h0);
    applyB(1'b1, 8'h44, 1'b0, 1'b0, 3'h0);
    checkOutput("b_load_q_out", 32'(bQOut), 32'h44);
    // Packed bits 3k..3k+2 of {0x11,0x22,0x33,0x44}; the last beat holds hist[3] bits 6,7 and the zero pad bit
    bExp = '{3'd4, 3'd0, 3'd5, 3'd1, 3'd3, 3'd4, 3'd0, 3'd1, 3'd1, 3'd2, 3'd0};
    bBeats = 0;
    bDoneCycle = -1;
    applyB(1'b0, 8'h00, 1'b1, 1'b0, 3'h0);
    for (int cyc = 1; cyc < 40; cyc++) begin
      if (bDone) begin
        bDoneCycle = cyc;
        break;
      end
      if (cyc >= 2 && bBeats < 11) begin
        checkOutput($sformatf("b_beat%0d", bBeats), 32'(bScanOut), 32'(bExp[bBeats]));
        bBeats++;
      end
      applyB(1'b0, 8'h00, 1'b0, 1'b1, 3'h0);
    end
    checkOutput("b_beat_count", 32'(bBeats), 32'd11);
    checkOutput("b_done_cycle", 32'(bDoneCycle), 32'd13);
    checkOutput("b_done_cnt", 32'(bBeatCnt), 32'd11);
    applyB(1'b0, 8'h00, 1'b0, 1'b0, 3'h0);

    applyB(1'b0, 8'h00, 1'b1, 1'b0, 3'h0);
    for (int cyc = 0; cyc < 20 && bBeatCnt != 5'd3; cyc++) begin
      applyB(1'b0, 8'h00, 1'b0, 1'b1, 3'h0);
    end
    checkOutput("b_mid_cnt", 32'(bBeatCnt), 32'd3);
    rstB = 1'b1;
    #1;
    checkOutput("b_rst_busy",     32'(bBusy),    32'h0);
    checkOutput("b_rst_done",     32'(bDone),    32'h0);
    checkOutput("b_rst_q_out",    32'(bQOut),    32'h0);
    checkOutput("b_rst_beat_cnt", 32'(bBeatCnt), 32'h0);
    checkOutput("b_rst_scan_out", 32'(bScanOut), 32'h0);
    @(posedge clk);
    #1 rstB = 1'b0;
    sawDone = 1'b0;
    for (int i = 0; i < 15; i++) begin
      applyB(1'b0, 8'h00, 1'b0, 1'b1, 3'h0);
      if (bDone || bBusy) sawDone = 1'b1;
    end
    checkOutput("b_no_done_after_rst", 32'(sawDone), 32'h0);

    $display("[TB] randomized run");
    for (int i = 0; i < 3000; i++) begin
      if ($urandom_range(199) == 0) begin
        #2 rst = 1'b1;
        @(posedge clk);
        #1 rst = 1'b0;
      end
      applyStimulus(1'($urandom_range(1)), 8'($urandom), ($urandom_range(7) == 0),
                    ($urandom_range(3) != 0), 4'($urandom));
    end

    $display("Simulation finished: %0d checks, %0d errors", checkCount, errorCount);
    $finish;
  end

  // Hard stop in case the stimulus ever stalls
  initial begin
    #2000000;
    $display("[TB] FAIL watchdog: got no finish, expected finish before time limit");
    $fatal(1, "[TB] watchdog expired");
  end

endmodule
